// File: rtl/delay_cascade_pkg.sv
// Shared types and constants for the delay-cascade controller.
// The tap-to-select mapping lives here so the cascade code table has a single home.
package delay_cascade_pkg;

    typedef logic [2:0] tap_t;

    localparam int NUM_TAPS = 5;

    localparam logic [3:0] TAP_CODE [NUM_TAPS] = '{4'h0, 4'h2, 4'h3, 4'h7, 4'hF};

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_QUIET = 2'd1,
        ST_SETTLE     = 2'd2,
        ST_DWELL      = 2'd3
    } dcc_state_t;

    function automatic logic tap_legal(input tap_t t);
        return (t < tap_t'(NUM_TAPS));
    endfunction

    // Out-of-range taps fall back to the bypass code so select stays in the legal set.
    function automatic logic [3:0] tap_code(input tap_t t);
        logic [3:0] c;
        case (t)
            3'd0:    c = TAP_CODE[0];
            3'd1:    c = TAP_CODE[1];
            3'd2:    c = TAP_CODE[2];
            3'd3:    c = TAP_CODE[3];
            3'd4:    c = TAP_CODE[4];
            default: c = TAP_CODE[0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/delay_cascade_ctrl_quiet.sv
// Quiet detector for the synchronised cascade input: counts consecutive
// unchanged samples, saturating at QUIET_CYCLES.
module line_quiet_detect #(
    parameter int QUIET_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_sync,
    output logic quiet
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);

    logic          prev_q;
    logic [QW-1:0] cnt_q;

    // Previous-sample register and saturating run-length counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= in_sync;
            if (in_sync != prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q != QW'(QUIET_CYCLES)) begin
                cnt_q <= cnt_q + QW'(1);
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    assign quiet = (cnt_q == QW'(QUIET_CYCLES));

endmodule

// File: rtl/delay_cascade_ctrl.sv
// Tap-change controller for the 4-stage delay cascade: applies requested taps
// only while the delayed line is quiet, and runs an autonomous 0..4 tap sweep.
module delay_cascade_ctrl
    import delay_cascade_pkg::*;
#(
    parameter int QUIET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_tap,
    input  logic               sweep_start,
    input  logic               sweep_abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               in_sync,
    output logic [3:0]         select,
    output logic [2:0]         cur_tap,
    output logic               busy,
    output logic               done,
    output logic               sweep_done,
    output logic               err
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;

    dcc_state_t         state_q;
    tap_t               tap_q;
    logic               sweep_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         select_q;
    tap_t               cur_tap_q;
    logic               busy_q;
    logic               req_ready_q;
    logic               done_q;
    logic               sweep_done_q;
    logic               err_q;
    logic               quiet_s;
    logic               step_last_s;

    line_quiet_detect #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_quiet (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_sync(in_sync),
        .quiet  (quiet_s)
    );

    // Abort is only honoured here, at the end of a fully applied step.
    assign step_last_s = (tap_q == tap_t'(NUM_TAPS - 1)) || sweep_abort;

    // Controller FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            sweep_q      <= 1'b0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            select_q     <= 4'h0;
            cur_tap_q    <= '0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    if (req_ready_q && sweep_start) begin
                        sweep_q     <= 1'b1;
                        dwell_q     <= dwell;
                        tap_q       <= '0;
                        state_q     <= ST_WAIT_QUIET;
                        busy_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                    end else if (req_ready_q && req_valid) begin
                        if (!tap_legal(req_tap)) begin
                            err_q <= 1'b1;
                        end else if (req_tap == cur_tap_q) begin
                            done_q <= 1'b1;
                        end else begin
                            sweep_q     <= 1'b0;
                            tap_q       <= req_tap;
                            state_q     <= ST_WAIT_QUIET;
                            busy_q      <= 1'b1;
                            req_ready_q <= 1'b0;
                        end
                    end
                end
                ST_WAIT_QUIET: begin
                    if (quiet_s) begin
                        select_q  <= tap_code(tap_q);
                        cur_tap_q <= tap_q;
                        cnt_q     <= CNT_W'(SETTLE_CYCLES - 1);
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!sweep_q) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end else if (dwell_q != '0) begin
                        cnt_q   <= CNT_W'(dwell_q - DWELL_W'(1));
                        state_q <= ST_DWELL;
                    end else if (step_last_s) begin
                        state_q      <= ST_IDLE;
                        sweep_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end else begin
                        tap_q   <= tap_q + tap_t'(1);
                        state_q <= ST_WAIT_QUIET;
                    end
                end
                ST_DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (step_last_s) begin
                        state_q      <= ST_IDLE;
                        sweep_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end else begin
                        tap_q   <= tap_q + tap_t'(1);
                        state_q <= ST_WAIT_QUIET;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign select     = select_q;
    assign cur_tap    = cur_tap_q;
    assign busy       = busy_q;
    assign req_ready  = req_ready_q;
    assign done       = done_q;
    assign sweep_done = sweep_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_delay_cascade_ctrl.sv
// Randomised bench for delay_cascade_ctrl; expected timing is derived from
// quiet/settle/dwell arithmetic rather than a cycle-level copy of the FSM.
module tb_delay_cascade_ctrl;

    localparam int Q = 4;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n, req_valid, req_ready, sweep_start, sweep_abort, in_sync;
    logic [2:0] req_tap, cur_tap;
    logic [7:0] dwell;
    logic [3:0] select;
    logic       busy, done, sweep_done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int cur_m = 0;
    logic [3:0] code_tbl [5] = '{4'h0, 4'h2, 4'h3, 4'h7, 4'hF};

    delay_cascade_ctrl #(.QUIET_CYCLES(Q), .SETTLE_CYCLES(S), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_tap(req_tap), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
        .dwell(dwell), .in_sync(in_sync), .select(select), .cur_tap(cur_tap),
        .busy(busy), .done(done), .sweep_done(sweep_done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_tap = 3'd0; sweep_start = 1'b0;
        sweep_abort = 1'b0; dwell = 8'd0; in_sync = 1'b0;
        repeat (3) tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low got=%b exp=0", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after got=%b exp=1", req_ready); end
        n_cmp++; if (select !== 4'h0) begin n_bad++; $display("FAIL rst_select got=%h exp=0", select); end
        n_cmp++; if (cur_tap !== 3'd0) begin n_bad++; $display("FAIL rst_cur_tap got=%0d exp=0", cur_tap); end
        n_cmp++; if ({busy, done, sweep_done, err} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_flags got=%b exp=0000", {busy, done, sweep_done, err});
        end
        cur_m = 0;
        repeat (6) tick();
    endtask

    // Leaves the bench in the cycle where done is high.
    task automatic test_request(input int t);
        logic [3:0] old_sel;
        old_sel = code_tbl[cur_m];
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL req_ready_pre got=%b exp=1", req_ready); end
        req_valid = 1'b1; req_tap = 3'(t);
        tick();
        req_valid = 1'b0;
        if (t == cur_m) begin
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL same_tap_done got=%b exp=1", done); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL same_tap_busy got=%b exp=0", busy); end
            n_cmp++; if (select !== old_sel) begin n_bad++; $display("FAIL same_tap_select got=%h exp=%h", select, old_sel); end
        end else begin
            n_cmp++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
                n_bad++; $display("FAIL req_accept busy/ready got=%b%b exp=10", busy, req_ready);
            end
            n_cmp++; if (select !== old_sel) begin n_bad++; $display("FAIL req_select_e0 got=%h exp=%h", select, old_sel); end
            tick();
            n_cmp++; if (select !== code_tbl[t]) begin n_bad++; $display("FAIL req_select_e1 got=%h exp=%h", select, code_tbl[t]); end
            n_cmp++; if (cur_tap !== 3'(t)) begin n_bad++; $display("FAIL req_cur_tap got=%0d exp=%0d", cur_tap, t); end
            cur_m = t;
            repeat (S - 1) begin
                tick();
                n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL req_done_early got=%b exp=0", done); end
            end
            tick();
            n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
                n_bad++; $display("FAIL req_done done/busy/ready got=%b%b%b exp=101", done, busy, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        t1 = (cur_m + 1) % 5;
        test_request(t1);
        test_request((t1 + 2) % 5);
        test_request(cur_m);
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_quiet_wait(input int t, input int gap_fixed);
        logic [3:0] old_sel;
        int ntog, g, last;
        old_sel = code_tbl[cur_m];
        ntog = $urandom_range(3, 6);
        in_sync = ~in_sync; req_valid = 1'b1; req_tap = 3'(t);
        tick();
        last = cyc; req_valid = 1'b0;
        for (int k = 1; k < ntog; k++) begin
            g = (gap_fixed > 0) ? gap_fixed : $urandom_range(1, Q);
            for (int j = 1; j < g; j++) begin
                tick();
                n_cmp++; if (select !== old_sel) begin n_bad++; $display("FAIL qw_hold got=%h exp=%h", select, old_sel); end
            end
            in_sync = ~in_sync;
            tick();
            last = cyc;
            n_cmp++; if (select !== old_sel || busy !== 1'b1) begin
                n_bad++; $display("FAIL qw_toggle select=%h busy=%b exp=%h 1", select, busy, old_sel);
            end
        end
        repeat (Q) begin
            tick();
            n_cmp++; if (select !== old_sel) begin n_bad++; $display("FAIL qw_quiet_hold got=%h exp=%h", select, old_sel); end
        end
        tick();
        n_cmp++; if (cyc != last + Q + 1 || select !== code_tbl[t]) begin
            n_bad++; $display("FAIL qw_apply select=%h exp=%h at +%0d", select, code_tbl[t], cyc - last);
        end
        n_cmp++; if (cur_tap !== 3'(t)) begin n_bad++; $display("FAIL qw_cur_tap got=%0d exp=%0d", cur_tap, t); end
        cur_m = t;
        repeat (S) tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL qw_done got=%b exp=1", done); end
    endtask

    task automatic test_illegal();
        logic [3:0] old_sel;
        old_sel = code_tbl[cur_m];
        for (int t = 5; t < 8; t++) begin
            req_valid = 1'b1; req_tap = 3'(t);
            tick();
            req_valid = 1'b0;
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err tap=%0d got=%b exp=1", t, err); end
            n_cmp++; if (select !== old_sel || cur_tap !== 3'(cur_m) || busy !== 1'b0) begin
                n_bad++; $display("FAIL illegal_state select=%h cur=%0d busy=%b exp=%h %0d 0", select, cur_tap, busy, old_sel, cur_m);
            end
            tick();
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL illegal_err_pulse got=%b exp=0", err); end
        end
    endtask

    // Step s is applied at a0 + s*p with p = S + dwell + 1 on a quiet line.
    task automatic test_sweep(input int d, input int abort_step, input int reset_step);
        logic [3:0] old_sel, exp_sel;
        int e0, a0, p, last, end_c, idx;
        old_sel = code_tbl[cur_m];
        p = S + d + 1;
        last = (abort_step >= 0) ? abort_step : 4;
        sweep_start = 1'b1; dwell = 8'(d); req_valid = 1'b1; req_tap = 3'd6;
        tick();
        sweep_start = 1'b0; req_valid = 1'b0; dwell = 8'($urandom_range(0, 255));
        e0 = cyc; a0 = e0 + 1; end_c = a0 + last * p + S + d;
        n_cmp++; if (busy !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL sw_start busy=%b err=%b exp=1 0", busy, err);
        end
        while (cyc < end_c) begin
            tick();
            idx = (cyc - a0) / p;
            if (idx > last) idx = last;
            exp_sel = code_tbl[idx];
            n_cmp++; if (select !== exp_sel) begin n_bad++; $display("FAIL sw_select cyc=%0d got=%h exp=%h", cyc - e0, select, exp_sel); end
            n_cmp++; if (sweep_done !== (cyc == end_c) || busy !== (cyc < end_c)) begin
                n_bad++; $display("FAIL sw_flags cyc=%0d sweep_done=%b busy=%b", cyc - e0, sweep_done, busy);
            end
            if (reset_step >= 0 && cyc == a0 + reset_step * p + 1) begin
                rst_n = 1'b0;
                tick();
                n_cmp++; if (select !== 4'h0 || cur_tap !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b0) begin
                    n_bad++; $display("FAIL sw_reset select=%h cur=%0d busy=%b ready=%b exp=0 0 0 0", select, cur_tap, busy, req_ready);
                end
                rst_n = 1'b1;
                tick();
                n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL sw_reset_release ready=%b busy=%b exp=1 0", req_ready, busy);
                end
                cur_m = 0;
                repeat (8) tick();
                return;
            end
            if (abort_step >= 0 && cyc == a0 + abort_step * p + 1) sweep_abort = 1'b1;
        end
        n_cmp++; if (req_ready !== 1'b1 || cur_tap !== 3'(last)) begin
            n_bad++; $display("FAIL sw_end ready=%b cur=%0d exp=1 %0d", req_ready, cur_tap, last);
        end
        sweep_abort = 1'b0;
        cur_m = last;
        tick();
        n_cmp++; if (sweep_done !== 1'b0 || select !== code_tbl[last]) begin
            n_bad++; $display("FAIL sw_after sweep_done=%b select=%h exp=0 %h", sweep_done, select, code_tbl[last]);
        end
        if (old_sel === 4'hx) $display("note: unexpected unknown start code");
    endtask

    initial begin
        test_reset();
        test_request(3);
        tick();
        test_quiet_wait(4, 2);
        tick();
        test_illegal();
        for (int i = 0; i < 8; i++) begin
            test_request($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) tick();
        end
        test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            tick();
            test_quiet_wait((cur_m + $urandom_range(1, 4)) % 5, 0);
        end
        tick();
        test_sweep(2, -1, -1);
        test_sweep(0, -1, -1);
        test_sweep(2, 2, -1);
        test_sweep($urandom_range(0, 3), $urandom_range(0, 4), -1);
        test_sweep(2, -1, 2);
        test_request(2);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_cascade_ctrl.md
# delay_cascade_ctrl

Synchronous controller for the 4-stage programmable delay cascade: converts tap requests (0–4) into the cascade's 4-bit `select` code and changes `select` only when the delayed signal has been quiet for a programmable window, so a tap change never cuts a pulse in flight. Also runs an autonomous tap sweep (0→4 with dwell) for characterisation and calibration. It sits in the clocked domain beside the cascade and drives its `select` input directly.

## Interface
- `QUIET_CYCLES`, default 4: consecutive unchanged `in_sync` samples required before `select` may change; must be ≥1.
- `SETTLE_CYCLES`, default 4: cycles held in SETTLE after a `select` change; must be ≥1.
- `DWELL_W`, default 8: width of the sweep dwell count.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: tap request valid.
- `req_ready` out 1: controller accepts a request or sweep start; high only in IDLE.
- `req_tap` in 3: requested tap, 0–4; values 5–7 are illegal.
- `sweep_start` in 1: start a sweep, sampled in IDLE.
- `sweep_abort` in 1: level; ends a sweep at the next step boundary.
- `dwell` in DWELL_W: per-step dwell cycles, latched at sweep start.
- `in_sync` in 1: the cascade input, already synchronised to `clk`; used for quiet detection.
- `select` out 4: cascade select code.
- `cur_tap` out 3: tap currently applied.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when a single request completes.
- `sweep_done` out 1: one-cycle pulse when a sweep ends, whether completed or aborted.
- `err` out 1: one-cycle pulse on an illegal tap request.

## Operation
- Tap-to-code map: 0→0x0, 1→0x2, 2→0x3, 3→0x7, 4→0xF. `select` never takes any other value.
- Reset values: `select` = 0x0, `cur_tap` = 0, state IDLE, quiet count 0, and `busy`, `done`, `sweep_done`, `err` all 0. `req_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Quiet count: updated every edge. It clears to 0 if `in_sync` differs from its previous sample, otherwise increments and saturates at `QUIET_CYCLES`. The line is quiet when the count equals `QUIET_CYCLES`.
- States: IDLE, WAIT_QUIET, SETTLE, DWELL.
- IDLE:
  - `sweep_start` takes priority over `req_valid` if both are high.
  - Illegal `req_tap`: the request is accepted, `err` pulses, and state stays IDLE.
  - `req_tap` equal to `cur_tap`: the request is accepted and `done` pulses the next cycle; there is no `select` change.
  - Otherwise: latch the tap and go to WAIT_QUIET.
  - Sweep start: latch `dwell`, set step tap = 0, go to WAIT_QUIET. Every sweep step is applied, including tap 0 when `cur_tap` is already 0.
- WAIT_QUIET: on an edge where the line is quiet, load `select`/`cur_tap` from the latched tap and go to SETTLE. There is no timeout.
- SETTLE: lasts exactly `SETTLE_CYCLES` cycles.
  - Single request: go to IDLE and pulse `done`.
  - Sweep: go to DWELL, or skip DWELL if `dwell` = 0.
- DWELL: lasts `dwell` cycles. Then:
  - If tap = 4 or `sweep_abort` is high: go to IDLE and pulse `sweep_done`.
  - Otherwise: increment the tap and go to WAIT_QUIET.
- Abort: `sweep_abort` is checked only at the step boundary. `select` is never left mid-change and keeps the last applied tap.
- Reset mid-operation returns everything to the reset values on the next edge, including `select` = 0x0.

## Timing
- Single request, line already quiet: accept on edge E0. At E1 `select` updates and state enters SETTLE. At E(1+`SETTLE_CYCLES`) state is IDLE and `done` = 1 for one cycle.
- If the last `in_sync` change is sampled at edge Ek, the earliest `select` update is at Ek+`QUIET_CYCLES`+1.
- `req_ready` and `busy` are mutually exclusive. A new request can be accepted in the same cycle `done` is high.
- All outputs are registered.

## Structure
- Package `delay_cascade_pkg` holds:
  - `tap_t` (logic [2:0]).
  - `NUM_TAPS` = 5.
  - The `TAP_CODE` constant array.
  - The state enum `dcc_state_t`.
- Sub-module `line_quiet_detect`: previous-sample register plus saturating counter, parameterised by `QUIET_CYCLES`, with output `quiet`.

## Test plan
All scenarios use QUIET=4 and SETTLE=4.
- Reset: hold `rst_n` low 3 cycles and release → `select` = 0x0, `cur_tap` = 0, `busy` = 0, and `req_ready` = 1 in the first cycle after release.
- Request tap 3 with `in_sync` static → `select` = 0x7 one edge after accept, and `done` pulses 5 edges after accept.
- Request tap 4 while `in_sync` toggles every 2 cycles → `select` holds 0x0 while toggling. Stop toggling → `select` = 0xF exactly 5 edges after the last change is sampled.
- Request tap 6 → `err` is high for one cycle; `select`, `cur_tap` and `busy` are unchanged.
- Sweep with `dwell` = 2 and quiet line → `select` steps 0x0, 0x2, 0x3, 0x7, 0xF, with each value held ≥ 6 cycles, and `sweep_done` pulses once with `select` = 0xF.
- Sweep with `sweep_abort` raised during the tap-2 SETTLE → the sweep ends after that step with `select` = 0x3 and `sweep_done` pulses. Repeat with `rst_n` low during SETTLE → the next edge gives `select` = 0x0 and state IDLE.
